// File: rtl/sr_pq_v2.sv
// sr_pq_v2: shift-register priority queue of up to DEPTH {key,value} entries.
// The queue stays sorted every cycle, and slot 0 (the head) is always shown on kvo.
// Equal keys leave in arrival order. A push and a pop in the same cycle replace
// the head, and this works even when the queue is full.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous flush of all entries
//   push, pop, kvi    operation strobes and the {key,value} to insert
//   kvo               head entry, all-zero when empty
//   count/full/empty  occupancy status (registered)
//   overflow          1-cycle pulse: push dropped because the queue was full
//   underflow         1-cycle pulse: pop while empty
module sr_pq_v2 #(
  parameter int unsigned KW        = 4,
  parameter int unsigned VW        = 4,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MIN_FIRST = 1'b0,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [KW+VW-1:0] kvi,
  output logic [KW+VW-1:0] kvo,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [KW-1:0] key_q [DEPTH];
  logic [VW-1:0] val_q [DEPTH];
  logic          vld_q [DEPTH];
  logic [KW-1:0] key_d [DEPTH];
  logic [VW-1:0] val_d [DEPTH];
  logic          vld_d [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Source array for insertion: the current slots, shifted up by one if the head leaves.
  logic [KW-1:0] src_k [DEPTH];
  logic [VW-1:0] src_v [DEPTH];
  logic          src_ok [DEPTH];
  logic          beats [DEPTH];

  logic [KW-1:0] new_k;
  logic [VW-1:0] new_v;
  logic          pop_eff, push_eff;

  assign new_k = kvi[KW+VW-1:VW];
  assign new_v = kvi[VW-1:0];

  // A pop is taken only when the queue holds something. A push is accepted if there is room, or if the head leaves in the same cycle.
  assign pop_eff  = pop && !empty_q;
  assign push_eff = push && (!full_q || pop_eff);

  // Next-state computation: optional shift-up, then sorted insert.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      src_k[i]  = key_q[i];
      src_v[i]  = val_q[i];
      src_ok[i] = vld_q[i];
    end
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        src_k[i]  = key_q[i+1];
        src_v[i]  = val_q[i+1];
        src_ok[i] = vld_q[i+1];
      end
      src_k[DEPTH-1]  = '0;
      src_v[DEPTH-1]  = '0;
      src_ok[DEPTH-1] = 1'b0;
    end

    // Strict compare puts a new key behind existing equal keys. Because the slots are sorted, beats[] is monotonic (once set, it stays set for all later slots).
    for (int i = 0; i < DEPTH; i++) begin
      if (MIN_FIRST) beats[i] = !src_ok[i] || (new_k < src_k[i]);
      else           beats[i] = !src_ok[i] || (new_k > src_k[i]);
    end

    for (int i = 0; i < DEPTH; i++) begin
      key_d[i] = src_k[i];
      val_d[i] = src_v[i];
      vld_d[i] = src_ok[i];
    end
    if (push_eff) begin
      if (beats[0]) begin
        key_d[0] = new_k;
        val_d[0] = new_v;
        vld_d[0] = 1'b1;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (beats[i-1]) begin
          key_d[i] = src_k[i-1];
          val_d[i] = src_v[i-1];
          vld_d[i] = src_ok[i-1];
        end else if (beats[i]) begin
          key_d[i] = new_k;
          val_d[i] = new_v;
          vld_d[i] = 1'b1;
        end
      end
    end

    count_d = count_q;
    if (push_eff && !pop_eff)      count_d = count_q + CW'(1);
    else if (pop_eff && !push_eff) count_d = count_q - CW'(1);
    ovf_d = push && !push_eff;
    unf_d = pop && empty_q;

    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_d[i] = '0;
        val_d[i] = '0;
        vld_d[i] = 1'b0;
      end
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
        vld_q[i] <= vld_d[i];
      end
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Invalid slots are held at zero, so the head reads all-zero when the queue is empty.
  assign kvo       = {key_q[0], val_q[0]};
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sr_pq_v2.sv
// Directed bench for sr_pq_v2. It drives one max-first instance and one min-first instance.
module tb_sr_pq_v2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       clr_a, push_a, pop_a;
  logic [7:0] kvi_a, kvo_a;
  logic [2:0] count_a;
  logic       full_a, empty_a, ovf_a, unf_a;

  logic       clr_b, push_b, pop_b;
  logic [7:0] kvi_b, kvo_b;
  logic [2:0] count_b;
  logic       full_b, empty_b, ovf_b, unf_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_pq_v2 #(.KW(4), .VW(4), .DEPTH(4), .MIN_FIRST(1'b0)) dut_max (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .push(push_a), .pop(pop_a), .kvi(kvi_a),
    .kvo(kvo_a), .count(count_a), .full(full_a), .empty(empty_a),
    .overflow(ovf_a), .underflow(unf_a));

  sr_pq_v2 #(.KW(4), .VW(4), .DEPTH(4), .MIN_FIRST(1'b1)) dut_min (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .push(push_b), .pop(pop_b), .kvi(kvi_b),
    .kvo(kvo_b), .count(count_b), .full(full_b), .empty(empty_b),
    .overflow(ovf_b), .underflow(unf_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one op to the max-first instance for a single cycle, then sample just after the edge.
  task automatic op_a(input logic pu, input logic po, input logic [7:0] kv);
    push_a = pu; pop_a = po; kvi_a = kv;
    @(posedge clk); #1;
    push_a = 1'b0; pop_a = 1'b0; kvi_a = '0;
  endtask

  task automatic op_b(input logic cl, input logic pu, input logic po, input logic [7:0] kv);
    clr_b = cl; push_b = pu; pop_b = po; kvi_b = kv;
    @(posedge clk); #1;
    clr_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; kvi_b = '0;
  endtask

  initial begin
    clr_a = 0; push_a = 0; pop_a = 0; kvi_a = '0;
    clr_b = 0; push_b = 0; pop_b = 0; kvi_b = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_kvo", 32'(kvo_a), 32'h00);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_empty", 32'(empty_a), 1);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_unf", 32'(unf_a), 0);

    // 1: sorted insertion, largest key at head
    op_a(1, 0, 8'h44); chk("t1_push44", 32'(kvo_a), 32'h44);
    op_a(1, 0, 8'h11); chk("t1_push11", 32'(kvo_a), 32'h44);
    op_a(1, 0, 8'h55); chk("t1_push55", 32'(kvo_a), 32'h55);
    op_a(1, 0, 8'h33); chk("t1_push33", 32'(kvo_a), 32'h55);
    chk("t1_count", 32'(count_a), 4);
    chk("t1_full", 32'(full_a), 1);
    op_a(0, 1, 8'h00); chk("t1_pop1", 32'(kvo_a), 32'h44);
    op_a(0, 1, 8'h00); chk("t1_pop2", 32'(kvo_a), 32'h33);
    op_a(0, 1, 8'h00); chk("t1_pop3", 32'(kvo_a), 32'h11);
    op_a(0, 1, 8'h00); chk("t1_pop4", 32'(kvo_a), 32'h00);
    chk("t1_empty", 32'(empty_a), 1);
    chk("t1_count0", 32'(count_a), 0);

    // 2: equal keys leave in arrival order
    op_a(1, 0, 8'h21);
    op_a(1, 0, 8'h22); chk("t2_head", 32'(kvo_a), 32'h21);
    op_a(0, 1, 8'h00); chk("t2_pop1", 32'(kvo_a), 32'h22);
    op_a(0, 1, 8'h00); chk("t2_pop2", 32'(kvo_a), 32'h00);

    // 3: overflow when full, then replace (push+pop) on a full queue
    op_a(1, 0, 8'h55); op_a(1, 0, 8'h44); op_a(1, 0, 8'h33); op_a(1, 0, 8'h11);
    op_a(1, 0, 8'h99);
    chk("t3_ovf", 32'(ovf_a), 1);
    chk("t3_ovf_kvo", 32'(kvo_a), 32'h55);
    chk("t3_ovf_count", 32'(count_a), 4);
    op_a(0, 0, 8'h00);
    chk("t3_ovf_pulse", 32'(ovf_a), 0);
    op_a(1, 1, 8'h99);
    chk("t3_rep_kvo", 32'(kvo_a), 32'h99);
    chk("t3_rep_count", 32'(count_a), 4);
    chk("t3_rep_ovf", 32'(ovf_a), 0);
    op_a(0, 1, 8'h00); chk("t3_pop1", 32'(kvo_a), 32'h44);
    op_a(0, 1, 8'h00); chk("t3_pop2", 32'(kvo_a), 32'h33);
    op_a(0, 1, 8'h00); chk("t3_pop3", 32'(kvo_a), 32'h11);
    op_a(0, 1, 8'h00); chk("t3_pop4", 32'(kvo_a), 32'h00);

    // 4: underflow, alone and combined with a push
    op_a(0, 1, 8'h00);
    chk("t4_unf", 32'(unf_a), 1);
    chk("t4_unf_count", 32'(count_a), 0);
    op_a(0, 0, 8'h00);
    chk("t4_unf_pulse", 32'(unf_a), 0);
    op_a(1, 1, 8'h77);
    chk("t4_pp_unf", 32'(unf_a), 1);
    chk("t4_pp_kvo", 32'(kvo_a), 32'h77);
    chk("t4_pp_count", 32'(count_a), 1);
    op_a(0, 1, 8'h00);
    chk("t4_drain", 32'(empty_a), 1);

    // 5: min-first ordering, asynchronous reset mid-cycle, clear overriding a push
    op_b(0, 1, 0, 8'h44); chk("t5_push44", 32'(kvo_b), 32'h44);
    op_b(0, 1, 0, 8'h11); chk("t5_push11", 32'(kvo_b), 32'h11);
    op_b(0, 1, 0, 8'h55);
    op_b(0, 1, 0, 8'h33); chk("t5_head", 32'(kvo_b), 32'h11);
    op_b(0, 0, 1, 8'h00); chk("t5_pop1", 32'(kvo_b), 32'h33);
    op_b(0, 0, 1, 8'h00); chk("t5_pop2", 32'(kvo_b), 32'h44);
    op_b(0, 0, 1, 8'h00); chk("t5_pop3", 32'(kvo_b), 32'h55);
    op_b(0, 0, 1, 8'h00); chk("t5_pop4", 32'(kvo_b), 32'h00);

    op_b(0, 1, 0, 8'h66);
    op_b(0, 1, 0, 8'h22);
    chk("t5_two_count", 32'(count_b), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_empty", 32'(empty_b), 1);
    chk("t5_arst_kvo", 32'(kvo_b), 32'h00);
    chk("t5_arst_count", 32'(count_b), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    op_b(0, 1, 0, 8'h33); op_b(0, 1, 0, 8'h88); op_b(0, 1, 0, 8'h11);
    chk("t5_three_count", 32'(count_b), 3);
    op_b(1, 1, 0, 8'hee);
    chk("t5_clr_count", 32'(count_b), 0);
    chk("t5_clr_kvo", 32'(kvo_b), 32'h00);
    chk("t5_clr_empty", 32'(empty_b), 1);
    chk("t5_clr_ovf", 32'(ovf_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
